// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC operand sequencer.
// Imported by the interface, the address generator and the top.
package mac_seq_pkg;

   localparam int N_DEF  = 32;
   localparam int AW_DEF = 8;
   localparam int LW_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      RUN,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Command, operand-RAM, MAC and result signals of one sequencer.
// master = environment side, slave = sequencer side.
interface mac_operand_sequencer_if
   import mac_seq_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF
);

   logic            start;
   logic [LW-1:0]   len;
   logic [AW-1:0]   a_base;
   logic [AW-1:0]   b_base;
   logic [AW-1:0]   b_stride;
   logic            busy;
   logic            a_rd_en;
   logic [AW-1:0]   a_addr;
   logic [N-1:0]    a_rdata;
   logic            b_rd_en;
   logic [AW-1:0]   b_addr;
   logic [N-1:0]    b_rdata;
   logic            mac_rst;
   logic [N-1:0]    mac_a;
   logic [N-1:0]    mac_b;
   logic [2*N-1:0]  mac_acc;
   logic            res_valid;
   logic            res_ready;
   logic [2*N-1:0]  res_data;

   modport master (
      output start, len, a_base, b_base, b_stride,
      output a_rdata, b_rdata, mac_acc, res_ready,
      input  busy, a_rd_en, a_addr, b_rd_en, b_addr,
      input  mac_rst, mac_a, mac_b, res_valid, res_data
   );

   modport slave (
      input  start, len, a_base, b_base, b_stride,
      input  a_rdata, b_rdata, mac_acc, res_ready,
      output busy, a_rd_en, a_addr, b_rd_en, b_addr,
      output mac_rst, mac_a, mac_b, res_valid, res_data
   );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// Element index and A/B read addresses; B stride is accumulated,
// so no multiplier is needed. Addresses wrap mod 2**AW.
module mac_seq_addr_gen
   import mac_seq_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] a_base,
   input  logic [AW-1:0] b_base,
   input  logic [AW-1:0] b_stride,
   output logic [LW-1:0] idx,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr
);

   logic [AW-1:0] stride;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         a_addr <= '0;
         b_addr <= '0;
         stride <= '0;
      end else if (load) begin
         idx    <= '0;
         a_addr <= a_base;
         b_addr <= b_base;
         stride <= b_stride;
      end else if (step) begin
         idx    <= idx + LW'(1);
         a_addr <= a_addr + AW'(1);
         b_addr <= b_addr + stride;
      end
   end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Fetches A row / B column pairs into a 1-stage MAC, then captures
// the dot product and offers it on a valid/ready result port.
module mac_operand_sequencer
   import mac_seq_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF
) (
   input logic                   clk,
   input logic                   rst_n,
   mac_operand_sequencer_if.slave bus
);

   state_t        st;
   logic [LW-1:0] len_q;
   logic [LW-1:0] idx;
   logic          rd;
   logic          op_vld;
   logic          load;

   assign load = (st == IDLE) && bus.start;
   assign rd   = ((st == CLR) || (st == RUN)) && (idx < len_q);

   mac_seq_addr_gen #(.AW(AW), .LW(LW)) u_addr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (rd),
      .a_base   (bus.a_base),
      .b_base   (bus.b_base),
      .b_stride (bus.b_stride),
      .idx      (idx),
      .a_addr   (bus.a_addr),
      .b_addr   (bus.b_addr)
   );

   assign bus.a_rd_en = rd;
   assign bus.b_rd_en = rd;
   // MAC is held clear while in reset so an aborted job leaves nothing behind
   assign bus.mac_rst = !rst_n || (st == CLR);
   assign bus.mac_a   = op_vld ? bus.a_rdata : '0;
   assign bus.mac_b   = op_vld ? bus.b_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= IDLE;
         len_q         <= '0;
         op_vld        <= 1'b0;
         bus.busy      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
      end else begin
         op_vld <= rd;
         unique case (st)
            IDLE: if (bus.start) begin
               len_q    <= bus.len;
               bus.busy <= 1'b1;
               st       <= CLR;
            end
            CLR:  st <= (len_q != '0) ? RUN : WAIT;
            RUN:  if (!rd) st <= WAIT;
            WAIT: begin
               bus.res_data  <= bus.mac_acc;
               bus.res_valid <= 1'b1;
               st            <= DONE;
            end
            DONE: if (bus.res_ready) begin
               bus.res_valid <= 1'b0;
               bus.busy      <= 1'b0;
               st            <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
